// File: rtl/vga_capture.sv
// vga_capture: recovers pixel position from VSYNC/HSYNC edges and writes a
// rectangular capture window of 16-bit pixels into a frame-buffer RAM at
// linear addresses. Single-shot or continuous capture with done/error pulses.
module vga_capture #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int CAP_X    = 0,
    parameter int CAP_Y    = 0,
    parameter int CAP_W    = 256,
    parameter int CAP_H    = 256,
    parameter bit SYNC_POL = 1'b1,
    parameter int ADDR_W   = 16
) (
    input  logic              CLK_40M,
    input  logic              RST,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [15:0]       DATA_IN,
    input  logic              ARM,
    input  logic              CONTINUOUS,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [15:0]       WR_DATA,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);

    localparam int unsigned H_LO = H_SYNC + H_BACK + CAP_X;
    localparam int unsigned H_HI = H_LO + CAP_W;
    localparam int unsigned V_LO = V_SYNC + V_BACK + CAP_Y;
    localparam int unsigned V_HI = V_LO + CAP_H;
    localparam int          PW   = ADDR_W + 1;
    localparam logic [ADDR_W:0] PIX_TOTAL = PW'(CAP_W * CAP_H);
    localparam logic SYNC_IDLE = ~SYNC_POL;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Stage-1 sync level went from inactive to active this cycle.
    function automatic logic assert_edge(input logic cur, input logic prev);
        return (cur == SYNC_POL) && (prev != SYNC_POL);
    endfunction

    logic          vsync_r, hsync_r, vsync_d_r, hsync_d_r;
    logic [15:0]   data_r;
    logic [11:0]   h_cnt_r, h_cnt_s;
    logic [10:0]   v_cnt_r, v_cnt_s;
    logic          v_edge_s, h_edge_s, in_win_s;
    state_t        state_r, next_state_s;
    logic [ADDR_W:0] pix_cnt_r, next_pix_s;
    logic          wr_s, done_s, err_s;

    assign v_edge_s = assert_edge(vsync_r, vsync_d_r);
    assign h_edge_s = assert_edge(hsync_r, hsync_d_r);

    // Stage-1 input registers plus the previous sync level for edge detection.
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            vsync_r   <= SYNC_IDLE;
            hsync_r   <= SYNC_IDLE;
            vsync_d_r <= SYNC_IDLE;
            hsync_d_r <= SYNC_IDLE;
            data_r    <= 16'd0;
        end else begin
            vsync_r   <= VSYNC;
            hsync_r   <= HSYNC;
            vsync_d_r <= vsync_r;
            hsync_d_r <= hsync_r;
            data_r    <= DATA_IN;
        end
    end

    // Column/line position of the stage-1 pixel; counters saturate, VSYNC wins.
    always_comb begin
        h_cnt_s = h_cnt_r;
        v_cnt_s = v_cnt_r;
        if (h_edge_s) begin
            h_cnt_s = 12'd0;
        end else if (h_cnt_r != 12'd4095) begin
            h_cnt_s = h_cnt_r + 12'd1;
        end else begin
            h_cnt_s = h_cnt_r;
        end
        if (v_edge_s) begin
            v_cnt_s = 11'd0;
        end else if (h_edge_s && (v_cnt_r != 11'd2047)) begin
            v_cnt_s = v_cnt_r + 11'd1;
        end else begin
            v_cnt_s = v_cnt_r;
        end
    end

    assign in_win_s = ({20'd0, h_cnt_s} >= H_LO) && ({20'd0, h_cnt_s} < H_HI) &&
                      ({21'd0, v_cnt_s} >= V_LO) && ({21'd0, v_cnt_s} < V_HI);

    // Position counter registers.
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 11'd0;
        end else begin
            h_cnt_r <= h_cnt_s;
            v_cnt_r <= v_cnt_s;
        end
    end

    // Capture FSM next-state, pixel counter and write/pulse decisions.
    always_comb begin
        next_state_s = state_r;
        next_pix_s   = pix_cnt_r;
        wr_s         = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ARM) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (v_edge_s) begin
                    next_state_s = ST_CAPTURE;
                    next_pix_s   = '0;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                if (v_edge_s) begin
                    if (pix_cnt_r == PIX_TOTAL) begin
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    next_pix_s   = '0;
                    next_state_s = CONTINUOUS ? ST_CAPTURE : ST_IDLE;
                end else if (in_win_s && (pix_cnt_r < PIX_TOTAL)) begin
                    wr_s       = 1'b1;
                    next_pix_s = pix_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    next_pix_s = pix_cnt_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_pix_s   = '0;
            end
        endcase
    end

    // FSM state and pixel counter registers.
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            pix_cnt_r <= '0;
        end else begin
            state_r   <= next_state_s;
            pix_cnt_r <= next_pix_s;
        end
    end

    // Stage-2 registered outputs; address/data hold between writes.
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= 16'd0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            WR_EN <= wr_s;
            if (wr_s) begin
                WR_ADDR <= pix_cnt_r[ADDR_W-1:0];
                WR_DATA <= data_r;
            end
            BUSY       <= (state_r != ST_IDLE);
            FRAME_DONE <= done_s;
            FRAME_ERR  <= err_s;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a shrunken, active-low-sync video
// timing: 20 clocks per line, 10 lines per frame, 4x3 window at offset (2,1).
module tb_vga_capture;

    localparam int H_TOT = 20;
    localparam int HS    = 4;
    localparam int HB    = 3;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int CX    = 2;
    localparam int CY    = 1;
    localparam int CW    = 4;
    localparam int CH    = 3;
    localparam int H_LO  = HS + HB + CX;   // 9
    localparam int H_HI  = H_LO + CW;      // 13
    localparam int V_LO  = VS + VB + CY;   // 5
    localparam int V_HI  = V_LO + CH;      // 8

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        vsync, hsync;
    logic [15:0] data_in;
    logic        arm, continuous;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy, frame_done, frame_err;

    exp_t        exp_q[$];
    logic [15:0] mem [0:15];
    int          checks = 0;
    int          errors = 0;

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .V_SYNC(VS), .V_BACK(VB),
        .CAP_X(CX), .CAP_Y(CY), .CAP_W(CW), .CAP_H(CH),
        .SYNC_POL(1'b0), .ADDR_W(16)
    ) dut (
        .CLK_40M(clk), .RST(rst), .VSYNC(vsync), .HSYNC(hsync),
        .DATA_IN(data_in), .ARM(arm), .CONTINUOUS(continuous),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .BUSY(busy), .FRAME_DONE(frame_done), .FRAME_ERR(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [1:0] kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: kind %0d with empty queue", kind);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", {30'd0, kind}, {30'd0, e.kind});
            if (kind == K_WR) begin
                check("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
                check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                if (wr_addr < 16'd16) mem[wr_addr[3:0]] = wr_data;
            end
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a write or a pulse.
    always @(negedge clk) begin
        if (frame_done && frame_err) check("done_err_exclusive", 32'd1, 32'd0);
        if (wr_en) expect_evt(K_WR);
        if (frame_done) expect_evt(K_DONE);
        if (frame_err) expect_evt(K_ERR);
    end

    // One source frame; pushes expected writes/pulses as the stimulus is issued.
    task automatic gen_frame(input int n_lines, input bit cap, input logic [1:0] evt,
                             input int arm_line, input int rst_line, input int busy_exp);
        int  widx = 0;
        bit  capping = cap;
        exp_t e;
        for (int line = 0; line < n_lines; line++) begin
            for (int col = 0; col < H_TOT; col++) begin
                vsync   = (line < VS) ? 1'b0 : 1'b1;
                hsync   = (col < HS) ? 1'b0 : 1'b1;
                data_in = {8'(line), 8'(col)};
                arm     = (line == arm_line) && (col == 0);
                rst     = (line == rst_line) && (col == 0);
                if (rst) capping = 1'b0;
                if ((line == 0) && (col == 0) && (evt != K_WR)) begin
                    e.kind = evt; e.addr = 16'd0; e.data = 16'd0;
                    exp_q.push_back(e);
                end
                if (capping && col >= H_LO && col < H_HI && line >= V_LO && line < V_HI
                    && widx < CW * CH) begin
                    e.kind = K_WR; e.addr = 16'(widx); e.data = data_in;
                    exp_q.push_back(e);
                    widx++;
                end
                @(posedge clk);
                #1;
                if ((line == rst_line) && (col == 0)) begin
                    check("abort_wr_en", {31'd0, wr_en}, 32'd0);
                    check("abort_busy", {31'd0, busy}, 32'd0);
                    check("abort_pulses", {30'd0, frame_done, frame_err}, 32'd0);
                end
                if ((busy_exp >= 0) && (line == 3) && (col == 0))
                    check("busy", {31'd0, busy}, 32'(busy_exp));
            end
        end
        arm = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; hsync = 1'b1; data_in = 16'd0;
        arm = 1'b0; continuous = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;

        // Reset held 3 cycles with syncs toggling: all outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            vsync = ~vsync; hsync = ~hsync; data_in = 16'hA5A5;
            @(posedge clk);
            #1;
            check("rst_outputs", {26'd0, wr_en, busy, frame_done, frame_err, |wr_addr, |wr_data}, 32'd0);
        end
        rst = 1'b0; vsync = 1'b1; hsync = 1'b1;
        @(posedge clk);
        #1;

        // Never armed: two frames, no writes.
        gen_frame(10, 1'b0, K_WR, -1, -1, 0);
        gen_frame(10, 1'b0, K_WR, -1, -1, 0);

        // Single shot, armed mid-window: that frame is skipped, next one captured.
        gen_frame(10, 1'b0, K_WR, 6, -1, 0);
        gen_frame(10, 1'b1, K_WR, -1, -1, 1);
        gen_frame(10, 1'b0, K_DONE, -1, -1, 0);
        gen_frame(10, 1'b0, K_WR, -1, -1, 0);
        check("mem0_first_pixel", {16'd0, mem[0]}, 32'h0509);
        check("mem4_next_line", {16'd0, mem[4]}, 32'h0609);
        check("mem11_last_pixel", {16'd0, mem[11]}, 32'h070C);

        // Continuous: three full frames, three DONE pulses, then back to idle.
        continuous = 1'b1;
        gen_frame(10, 1'b0, K_WR, 8, -1, 0);
        gen_frame(10, 1'b1, K_WR, -1, -1, 1);
        gen_frame(10, 1'b1, K_DONE, -1, -1, 1);
        gen_frame(10, 1'b1, K_DONE, -1, -1, 1);
        continuous = 1'b0;
        gen_frame(10, 1'b0, K_DONE, -1, -1, 0);

        // Short frame: only two window lines arrive before the next VSYNC.
        gen_frame(10, 1'b0, K_WR, 8, -1, 0);
        gen_frame(7, 1'b1, K_WR, -1, -1, 1);
        gen_frame(10, 1'b0, K_ERR, -1, -1, 0);

        // Abort: RST mid-capture stops writes, no pulse afterwards.
        gen_frame(10, 1'b0, K_WR, 8, -1, 0);
        gen_frame(10, 1'b1, K_WR, -1, 6, 1);
        gen_frame(10, 1'b0, K_WR, -1, -1, 0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing/pixel generator: samples VSYNC, HSYNC and 16-bit pixel data on the 40 MHz pixel clock.
- Recovers pixel column and line position from the sync edges, then writes a rectangular capture window into a frame-buffer RAM, one word per pixel, at linear addresses.
- Sits between an external or looped-back VGA source and a RAM IP write port.
- Supports single-shot capture or continuous capture, and reports frame completion or a geometry error.

Parameters:
- H_SYNC, 128: HSYNC pulse width in clocks.
- H_BACK, 88: horizontal back porch in clocks.
- V_SYNC, 4: VSYNC pulse width in lines.
- V_BACK, 23: vertical back porch in lines.
- CAP_X, 0: first captured column, relative to the start of active video.
- CAP_Y, 0: first captured line, relative to the start of active video.
- CAP_W, 256: captured width in pixels.
- CAP_H, 256: captured height in lines.
- SYNC_POL, 1: 1 means sync pulses are active-high; 0 means active-low.
- ADDR_W, 16: write address width. CAP_W*CAP_H must be ≤ 2^ADDR_W.

Ports:
- CLK_40M  in  1  pixel clock; everything is in this domain.
- RST  in  1  synchronous, active-high reset.
- VSYNC  in  1  vertical sync from the source.
- HSYNC  in  1  horizontal sync from the source.
- DATA_IN  in  16  RGB565 pixel data.
- ARM  in  1  one-cycle pulse that starts a capture.
- CONTINUOUS  in  1  level; 1 re-arms automatically after each frame.
- WR_EN  out  1  RAM write enable.
- WR_ADDR  out  ADDR_W  RAM write address.
- WR_DATA  out  16  RAM write data.
- BUSY  out  1  high whenever state ≠ IDLE.
- FRAME_DONE  out  1  one-cycle pulse: a full frame was written.
- FRAME_ERR  out  1  one-cycle pulse: the frame ended with the wrong pixel count.

Behaviour:
- Reset (RST sampled high at a clock edge):
  - state=IDLE; all counters 0; every output 0.
  - Input registers cleared to the inactive sync level.
  - RST asserted mid-capture aborts immediately; no DONE or ERR pulse is issued.
- Input stage:
  - VSYNC, HSYNC and DATA_IN are registered once (stage 1).
  - An assert edge is stage-1 sync going inactive→active, with polarity set by SYNC_POL.
- h_cnt (12 bit):
  - Set to 0 on the cycle an HSYNC assert edge is seen; otherwise increments.
  - Saturates at 4095 and does not wrap.
- v_cnt (11 bit):
  - Set to 0 on a VSYNC assert edge.
  - Otherwise increments on each HSYNC assert edge; saturates at 2047.
  - If both edges fall on the same cycle, VSYNC wins: v_cnt=0.
- In-window test for the stage-1 pixel: in_win when both of these hold:
  - H_SYNC+H_BACK+CAP_X ≤ h_cnt < H_SYNC+H_BACK+CAP_X+CAP_W.
  - V_SYNC+V_BACK+CAP_Y ≤ v_cnt < V_SYNC+V_BACK+CAP_Y+CAP_H.
- FSM states IDLE, WAIT_FRAME, CAPTURE:
  - IDLE: ARM=1 → WAIT_FRAME. ARM is ignored in every other state.
  - WAIT_FRAME: VSYNC assert edge → CAPTURE, with pix_cnt=0.
  - CAPTURE: each in_win cycle with pix_cnt < CAP_W*CAP_H writes one word and increments pix_cnt. Pixels beyond that count are dropped (no write, no address wrap).
  - CAPTURE, on the next VSYNC assert edge:
    - FRAME_DONE pulses if pix_cnt == CAP_W*CAP_H; otherwise FRAME_ERR pulses.
    - Next state is CAPTURE with pix_cnt=0 if CONTINUOUS=1, else IDLE.
- Output stage (stage 2, registered):
  - Write cycle: WR_EN=1, WR_ADDR=pix_cnt before increment, WR_DATA=stage-1 DATA_IN.
  - Non-write cycle: WR_EN=0; WR_ADDR and WR_DATA hold their last values.
  - Latency: a pixel on DATA_IN at edge n appears on WR_DATA/WR_EN after edge n+2.
- BUSY and the pulses:
  - BUSY is a registered copy of (state ≠ IDLE).
  - FRAME_DONE and FRAME_ERR are registered and are never high together.
- A frame begun before ARM (mid-frame arming) is never captured, because capture always starts at a VSYNC assert edge.

Test Plan:
- Reset/idle: RST high for 3 cycles with sync toggling → every output 0, BUSY=0, no WR_EN; ARM never pulsed → no writes over 2 frames.
- Single shot, 800x600@60 source timing, pixel=counter pattern:
  - ARM once → exactly 65536 writes, addresses 0..65535 in order.
  - Address 0 holds the source word at h_cnt=216, v_cnt=27.
  - Address 256 holds the word at column 0 of line 28.
  - One FRAME_DONE pulse, then BUSY=0; the next frame produces no writes.
- Continuous: CONTINUOUS=1, 3 frames → 3 FRAME_DONE pulses, address resets to 0 at each VSYNC edge, no FRAME_ERR.
- Short frame: VSYNC asserted after only 100 active lines → FRAME_ERR pulse, 25600 writes, no FRAME_DONE.
- Mid-frame arm plus abort:
  - ARM at line 300 → zero writes until the next VSYNC edge.
  - RST at line 50 of capture → WR_EN=0 the next cycle, state=IDLE, no pulse.
- Offset window with SYNC_POL=0 (CAP_X=10, CAP_Y=5, CAP_W=4, CAP_H=2) → writes go to addresses 0..7, taken from h_cnt 226..229 at v_cnt 32..33; first write lands 2 cycles after the pixel.
